// File: rtl/image_frame_gate.sv
//============================================================================
// Module : image_frame_gate
// Brief  : Frame-aligned capture gate with frame count, decimation and stop.
// Rev    : 1.0
//============================================================================
`default_nettype none

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 4'h1
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h2
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h3
`endif

module image_frame_gate #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    start,
    input  logic                    stop,
    input  logic [CNT_WIDTH-1:0]    num_frames,
    input  logic [7:0]              skip,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]   datai,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [DATA_WIDTH-1:0]   datao,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    frames_done,
    output logic                    done
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ARM  = 2'd1;
    localparam logic [1:0] c_ST_PASS = 2'd2;
    localparam logic [1:0] c_ST_SKIP = 2'd3;

    localparam logic [`DTYPE_WIDTH-1:0] c_DT_HS = `DTYPE_HEADER_START;
    localparam logic [`DTYPE_WIDTH-1:0] c_DT_FS = `DTYPE_FRAME_START;
    localparam logic [`DTYPE_WIDTH-1:0] c_DT_FE = `DTYPE_FRAME_END;
    localparam logic [CNT_WIDTH-1:0]    c_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH:0]      c_CNT_ONE1 = {{CNT_WIDTH{1'b0}}, 1'b1};

    logic [1:0]              r_state_q,    w_state_d;
    logic                    r_open_q,     w_open_d;
    logic                    r_pend_q,     w_pend_d;
    logic                    r_done_req_q, w_done_req_d;
    logic                    r_done_q,     w_done_d;
    logic [CNT_WIDTH-1:0]    r_frames_q,   w_frames_d;
    logic [CNT_WIDTH-1:0]    r_num_lat_q,  w_num_lat_d;
    logic [7:0]              r_skip_lat_q, w_skip_lat_d;
    logic [7:0]              r_skip_cnt_q, w_skip_cnt_d;
    logic                    r_dvo_q,      w_dvo_d;
    logic [`DTYPE_WIDTH-1:0] r_dtype_q,    w_dtype_d;
    logic [DATA_WIDTH-1:0]   r_data_q,     w_data_d;

    logic                    w_open_evt;
    logic                    w_close_evt;
    logic                    w_arm_open;
    logic                    w_last;
    logic                    w_pass;
    logic [CNT_WIDTH-1:0]    w_frames_inc;

    always_comb begin
        w_open_evt   = dvi && ((dtypei == c_DT_HS) || ((dtypei == c_DT_FS) && !r_open_q));
        w_close_evt  = dvi && (dtypei == c_DT_FE) && r_open_q;
        // ARM only accepts an open from a closed stream, so a unit already in
        // flight at start time (or restarted by a header) is never picked up.
        w_arm_open   = w_open_evt && !r_open_q;
        w_frames_inc = (&r_frames_q) ? r_frames_q : (r_frames_q + c_CNT_ONE);
        w_last       = (r_num_lat_q != '0) &&
                       (({1'b0, r_frames_q} + c_CNT_ONE1) == {1'b0, r_num_lat_q});

        w_state_d    = r_state_q;
        w_pend_d     = r_pend_q;
        w_done_req_d = 1'b0;
        w_frames_d   = r_frames_q;
        w_num_lat_d  = r_num_lat_q;
        w_skip_lat_d = r_skip_lat_q;
        w_skip_cnt_d = r_skip_cnt_q;
        w_pass       = 1'b0;

        if (w_open_evt) begin
            w_open_d = 1'b1;
        end else if (w_close_evt) begin
            w_open_d = 1'b0;
        end else begin
            w_open_d = r_open_q;
        end

        if (!enable) begin
            w_state_d = c_ST_IDLE;
            w_pend_d  = 1'b0;
        end else begin
            case (r_state_q)
                c_ST_IDLE: begin
                    if (start) begin
                        w_state_d    = c_ST_ARM;
                        w_num_lat_d  = num_frames;
                        w_skip_lat_d = skip;
                        w_skip_cnt_d = 8'd0;
                        w_frames_d   = '0;
                        w_pend_d     = 1'b0;
                    end
                end
                c_ST_ARM: begin
                    if (stop) begin
                        w_state_d    = c_ST_IDLE;
                        w_pend_d     = 1'b0;
                        w_done_req_d = 1'b1;
                    end else if (w_arm_open) begin
                        if (r_skip_cnt_q != 8'd0) begin
                            w_state_d = c_ST_SKIP;
                        end else begin
                            w_state_d = c_ST_PASS;
                            w_pass    = 1'b1;
                        end
                    end
                end
                c_ST_SKIP: begin
                    if (stop) begin
                        w_state_d    = c_ST_IDLE;
                        w_pend_d     = 1'b0;
                        w_done_req_d = 1'b1;
                    end else if (w_close_evt) begin
                        w_state_d    = c_ST_ARM;
                        w_skip_cnt_d = r_skip_cnt_q - 8'd1;
                    end
                end
                default: begin
                    w_pass = 1'b1;
                    if (w_close_evt) begin
                        w_frames_d = w_frames_inc;
                        if (w_last || r_pend_q || stop) begin
                            w_state_d    = c_ST_IDLE;
                            w_pend_d     = 1'b0;
                            w_done_req_d = 1'b1;
                        end else begin
                            w_state_d    = c_ST_ARM;
                            w_skip_cnt_d = r_skip_lat_q;
                        end
                    end else if (stop) begin
                        w_pend_d = 1'b1;
                    end
                end
            endcase
        end

        // done trails the IDLE entry by one cycle
        w_done_d = enable && r_done_req_q;

        if (!enable) begin
            w_dvo_d   = dvi;
            w_dtype_d = dtypei;
            w_data_d  = datai;
        end else if (w_pass && dvi) begin
            w_dvo_d   = 1'b1;
            w_dtype_d = dtypei;
            w_data_d  = datai;
        end else begin
            w_dvo_d   = 1'b0;
            w_dtype_d = '0;
            w_data_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= c_ST_IDLE;
            r_open_q     <= 1'b0;
            r_pend_q     <= 1'b0;
            r_done_req_q <= 1'b0;
            r_done_q     <= 1'b0;
            r_frames_q   <= '0;
            r_num_lat_q  <= '0;
            r_skip_lat_q <= 8'd0;
            r_skip_cnt_q <= 8'd0;
            r_dvo_q      <= 1'b0;
            r_dtype_q    <= '0;
            r_data_q     <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_open_q     <= w_open_d;
            r_pend_q     <= w_pend_d;
            r_done_req_q <= w_done_req_d;
            r_done_q     <= w_done_d;
            r_frames_q   <= w_frames_d;
            r_num_lat_q  <= w_num_lat_d;
            r_skip_lat_q <= w_skip_lat_d;
            r_skip_cnt_q <= w_skip_cnt_d;
            r_dvo_q      <= w_dvo_d;
            r_dtype_q    <= w_dtype_d;
            r_data_q     <= w_data_d;
        end
    end

    assign dvo         = r_dvo_q;
    assign dtypeo      = r_dtype_q;
    assign datao       = r_data_q;
    assign busy        = (r_state_q != c_ST_IDLE);
    assign frames_done = r_frames_q;
    assign done        = r_done_q;

endmodule

`default_nettype wire

// File: doc/image_frame_gate.md
IMAGE_FRAME_GATE -- requirements
Module: image_frame_gate

Interface
REQ-001 Parameter DATA_WIDTH, default 16, is the pixel/data word width.
REQ-002 Parameter CNT_WIDTH, default 16, is the width of the frame-count and frames-done fields.
REQ-003 clk  input  1  is the single clock; all logic is on its rising edge.
REQ-004 reset  input  1  is the synchronous, active-high reset.
REQ-005 enable  input  1  selects gating when 1 and registered pass-through when 0.
REQ-006 start  input  1  is a one-cycle capture request.
REQ-007 stop  input  1  is a one-cycle request to end capture at the next frame boundary.
REQ-008 num_frames  input  CNT_WIDTH  is the number of frames to pass; 0 means continuous.
REQ-009 skip  input  8  is the number of frames dropped after each passed frame (decimation).
REQ-010 dvi  input  1  is input data valid.
REQ-011 dtypei  input  `DTYPE_WIDTH  is the input data type code.
REQ-012 datai  input  DATA_WIDTH  is input data.
REQ-013 dvo, dtypeo, datao  output reg  1 / `DTYPE_WIDTH / DATA_WIDTH  is the gated output stream.
REQ-014 busy  output  1  is high in any state other than IDLE.
REQ-015 frames_done  output  CNT_WIDTH  counts frames passed since the last accepted start.
REQ-016 done  output  1  is a one-cycle pulse when a capture sequence completes.

Function
REQ-017 A frame unit opens on a dvi beat with `DTYPE_HEADER_START, or with `DTYPE_FRAME_START when no unit is open; it closes on a dvi beat with `DTYPE_FRAME_END, inclusive.
REQ-018 Latency is exactly 1 cycle: a passed input beat appears on dvo/dtypeo/datao on the next cycle.
REQ-019 A dropped beat drives dvo=0, dtypeo=0, datao=0 on that next cycle, as does any cycle with dvi=0.
REQ-020 The states are IDLE, ARM, PASS and SKIP.
REQ-021 IDLE drops all beats; start moves it to ARM, latches num_frames and skip into internal registers, and clears frames_done.
REQ-022 If start arrives while a frame unit is open in the input stream, ARM waits for that unit to close before it evaluates any open.
REQ-023 A unit open in ARM goes to PASS, and the opening beat itself is passed.
REQ-024 In PASS all beats are passed; on the closing beat, frames_done increments, and then:
  - if latched num_frames!=0 and frames_done+1==num_frames, or a stop is pending, the state goes to IDLE and done pulses on the following cycle;
  - otherwise, if latched skip!=0, the state goes to ARM with skip_cnt=skip and the next skip units are routed to SKIP;
  - otherwise the state goes to ARM.
REQ-025 A unit opening in ARM with skip_cnt!=0 goes to SKIP; all beats are dropped, and the closing beat decrements skip_cnt and returns to ARM.
REQ-026 stop sets a pending flag; from ARM or SKIP it goes to IDLE immediately with a done pulse; from PASS it takes effect at the unit close.
REQ-027 Simultaneous start and stop: stop wins in non-IDLE states, and start wins in IDLE.
REQ-028 start in a non-IDLE state is ignored.
REQ-029 frames_done saturates at all-ones and never wraps.
REQ-030 When enable=0: outputs equal the inputs delayed 1 cycle, the state is forced to IDLE, the pending flag is cleared, done=0, and frames_done is held.
REQ-031 A unit-open tracker follows the input stream in all states and modes, so that frame alignment is preserved across enable and state changes.
REQ-032 A header-start beat seen while a unit is already open restarts the unit; the current state is kept.

Reset
REQ-033 On reset=1 at a clock edge: state=IDLE, dvo=0, dtypeo=0, datao=0, busy=0, done=0, frames_done=0, skip_cnt=0, stop pending=0, unit-open tracker=0.
REQ-034 Reset mid-frame abandons the frame without emitting a closing beat; the next complete unit after release is handled per REQ-021 to REQ-025.

Verification
REQ-035 enable=0 with a random stream -> output equals the input delayed 1 cycle, bit-exact.
REQ-036 start with num_frames=3, skip=0, and 5 frames driven -> frames 1-3 passed, frames_done=3, done pulses once 1 cycle after frame 3 FRAME_END is output, frames 4-5 dropped.
REQ-037 start with num_frames=2, skip=2, and 8 frames -> frames 1 and 4 passed, frames_done=2, done pulses, frames 2, 3 and 5-8 dropped.
REQ-038 start mid-frame with num_frames=0, then stop during the 2nd passed frame -> the partial frame is dropped, two complete frames are passed, then IDLE, done=1 for one cycle.
REQ-039 Reset asserted mid-PASS, then start and 1 frame with num_frames=1 -> outputs cleared on the reset cycle, the next frame is passed whole, frames_done=1.
REQ-040 Simultaneous start and stop in IDLE, then 1 frame -> state ARM, then PASS, and the frame is passed.
